dmem_ctrl: RTL and testbench

Data-memory responder for the core's MEM stage: accepts the MEM stage's 32-bit load/store request (chip enable, write enable, byte-lane select, address, write data) and serves it against a byte-wide synchronous RAM, one byte per cycle. While a transfer is in flight it raises a stall request toward ctrl, which freezes the pipeline. When the transfer finishes, it presents the assembled load word for one cycle. It sits between mem and the external data RAM, alongside ctrl in the top level.

---
 rtl/dmem_ctrl.sv | 169 ++++++++++++++++
 tb/tb_dmem_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Byte-serial data-memory responder between the MEM stage and a byte-wide sync RAM.
// Build option: DMEM_LANE_SKIP_EN makes loads fetch only the enabled lanes.
module dmem_ctrl #(
    parameter int RAM_AW = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [31:0]       mem_data_i,
    output logic [31:0]       mem_data_o,
    output logic              stallreq_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic              ram_wr_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [RAM_AW-1:0] base_q, base_d;
    logic [3:0]        rem_q, rem_d;
    logic [1:0]        lane_q, lane_d;
    logic              cap_q, cap_d;
    logic [1:0]        cap_lane_q, cap_lane_d;
    logic [31:0]       data_q, data_d;
    logic [RAM_AW-1:0] addr_q, addr_d;

    logic [3:0]        xmask;
    logic [1:0]        nxt_lane;
    logic [RAM_AW-1:0] new_base;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{mem_addr_i[31:RAM_AW], mem_addr_i[1:0]};

    function automatic logic [1:0] low_lane(input logic [3:0] m);
        logic [1:0] l;
        l = 2'd3;
        if (m[2]) l = 2'd2;
        if (m[1]) l = 2'd1;
        if (m[0]) l = 2'd0;
        return l;
    endfunction

    always_comb begin
`ifdef DMEM_LANE_SKIP_EN
        xmask = mem_sel_i;
`else
        // loads always walk the whole word; stores stay masked
        xmask = mem_we_i ? mem_sel_i : 4'hF;
`endif
    end

    assign new_base = {mem_addr_i[RAM_AW-1:2], 2'b00};

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        sel_d      = sel_q;
        wdata_d    = wdata_q;
        base_d     = base_q;
        rem_d      = rem_q;
        lane_d     = lane_q;
        cap_d      = cap_q;
        cap_lane_d = cap_lane_q;
        data_d     = data_q;
        addr_d     = addr_q;
        nxt_lane   = 2'd0;
        unique case (state_q)
            S_IDLE: begin
                cap_d = 1'b0;
                if (mem_ce_i) begin
                    we_d    = mem_we_i;
                    sel_d   = mem_sel_i;
                    wdata_d = mem_data_i;
                    base_d  = new_base;
                    data_d  = 32'h0;
                    if (xmask == 4'h0) begin
                        state_d = S_DONE;
                    end else begin
                        nxt_lane = low_lane(xmask);
                        lane_d   = nxt_lane;
                        addr_d   = new_base + {{(RAM_AW-2){1'b0}}, nxt_lane};
                        rem_d    = xmask & ~(4'b0001 << nxt_lane);
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // byte for the lane issued last cycle arrives now
                if (cap_q && sel_q[cap_lane_q])
                    data_d[{cap_lane_q, 3'b000} +: 8] = ram_din_i;
                cap_d      = ~we_q;
                cap_lane_d = lane_q;
                if (rem_q != 4'h0) begin
                    nxt_lane = low_lane(rem_q);
                    lane_d   = nxt_lane;
                    addr_d   = base_q + {{(RAM_AW-2){1'b0}}, nxt_lane};
                    rem_d    = rem_q & ~(4'b0001 << nxt_lane);
                end else begin
                    state_d = we_q ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cap_q && sel_q[cap_lane_q])
                    data_d[{cap_lane_q, 3'b000} +: 8] = ram_din_i;
                cap_d   = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            sel_q      <= 4'h0;
            wdata_q    <= 32'h0;
            base_q     <= '0;
            rem_q      <= 4'h0;
            lane_q     <= 2'd0;
            cap_q      <= 1'b0;
            cap_lane_q <= 2'd0;
            data_q     <= 32'h0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            wdata_q    <= wdata_d;
            base_q     <= base_d;
            rem_q      <= rem_d;
            lane_q     <= lane_d;
            cap_q      <= cap_d;
            cap_lane_q <= cap_lane_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
        end
    end

    always_comb begin
        stallreq_o = 1'b0;
        unique case (state_q)
            S_IDLE:  stallreq_o = mem_ce_i;
            S_ISSUE: stallreq_o = 1'b1;
            S_WAIT:  stallreq_o = 1'b1;
            default: stallreq_o = 1'b0;
        endcase
    end

    assign ram_wr_o   = (state_q == S_ISSUE) & we_q;
    assign ram_dout_o = ram_wr_o ? wdata_q[{lane_q, 3'b000} +: 8] : 8'h00;
    assign ram_addr_o = addr_q;
    assign mem_data_o = (state_q == S_DONE) ? data_q : 32'h0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized bench for dmem_ctrl: transaction-level model predicts every output cycle.
// RAM is modelled here; a shadow memory holds the expected contents.
module tb_dmem_ctrl;

    localparam int AW = 17;

    typedef struct {
        bit          stall;
        bit          wr;
        bit [7:0]    dout;
        bit [AW-1:0] addr;
        bit [31:0]   data;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mem_ce_i = 1'b1;
    logic          mem_we_i = 1'b0;
    logic [31:0]   mem_addr_i = 32'h0;
    logic [3:0]    mem_sel_i = 4'h0;
    logic [31:0]   mem_data_i = 32'h0;
    logic [31:0]   mem_data_o;
    logic          stallreq_o;
    logic [AW-1:0] ram_addr_o;
    logic          ram_wr_o;
    logic [7:0]    ram_dout_o;
    logic [7:0]    ram_din_i = 8'h0;

    bit [7:0]    sim_ram [0:(1<<AW)-1];
    bit [7:0]    ref_mem [0:(1<<AW)-1];
    rec_t        exp_q[$];
    rec_t        cr;
    bit [AW-1:0] last_addr = '0;
    int          vectors = 0;
    int          miscompares = 0;

    dmem_ctrl #(.RAM_AW(AW)) dut (
        .clk(clk), .rst(rst),
        .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i),
        .mem_addr_i(mem_addr_i), .mem_sel_i(mem_sel_i),
        .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
        .stallreq_o(stallreq_o), .ram_addr_o(ram_addr_o),
        .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o),
        .ram_din_i(ram_din_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr_o) sim_ram[ram_addr_o] <= ram_dout_o;
        ram_din_i <= sim_ram[ram_addr_o];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst && exp_q.size() > 0) begin
            cr = exp_q.pop_front();
            chk("stallreq", {31'h0, stallreq_o}, {31'h0, cr.stall});
            chk("ram_wr", {31'h0, ram_wr_o}, {31'h0, cr.wr});
            chk("ram_dout", {24'h0, ram_dout_o}, {24'h0, cr.dout});
            chk("ram_addr", {15'h0, ram_addr_o}, {15'h0, cr.addr});
            chk("mem_data", mem_data_o, cr.data);
        end
    end

    task automatic push(input bit s, input bit w, input bit [7:0] d,
                        input bit [AW-1:0] a, input bit [31:0] dt);
        rec_t r;
        r.stall = s; r.wr = w; r.dout = d; r.addr = a; r.data = dt;
        exp_q.push_back(r);
    endtask

    task automatic rand_inputs();
        mem_ce_i   = 1'b0;
        mem_we_i   = 1'($urandom);
        mem_addr_i = $urandom;
        mem_sel_i  = 4'($urandom);
        mem_data_i = $urandom;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            push(1'b0, 1'b0, 8'h0, last_addr, 32'h0);
            @(posedge clk); #1;
        end
    endtask

    // Called at posedge+1; cycle 0 is the cycle that starts now.
    task automatic do_req(input bit we, input logic [31:0] addr, input logic [3:0] sel,
                          input logic [31:0] wd, output logic [31:0] dd, output int dc);
        bit [3:0]    xm;
        bit [AW-1:0] base;
        bit [AW-1:0] a;
        int          n;
`ifdef DMEM_LANE_SKIP_EN
        xm = sel;
`else
        xm = we ? sel : 4'hF;
`endif
        base = addr[AW-1:0] & ~(AW'(3));
        dd = 32'h0;
        n = 0;
        push(1'b1, 1'b0, 8'h0, last_addr, 32'h0);
        for (int i = 0; i < 4; i++) begin
            if (xm[i]) begin
                a = base + AW'(i);
                last_addr = a;
                n++;
                if (we) begin
                    ref_mem[a] = wd[8*i +: 8];
                    push(1'b1, 1'b1, wd[8*i +: 8], a, 32'h0);
                end else begin
                    if (sel[i]) dd[8*i +: 8] = ref_mem[a];
                    push(1'b1, 1'b0, 8'h0, a, 32'h0);
                end
            end
        end
        if (n > 0 && !we) push(1'b1, 1'b0, 8'h0, last_addr, 32'h0);
        push(1'b0, 1'b0, 8'h0, last_addr, dd);
        dc = 1 + n + ((n > 0 && !we) ? 1 : 0);
        mem_ce_i   = 1'b1;
        mem_we_i   = we;
        mem_addr_i = addr;
        mem_sel_i  = sel;
        mem_data_i = wd;
        repeat (dc + 1) @(posedge clk);
        #1;
        rand_inputs();
    endtask

    initial begin
        logic [31:0] dd;
        int          dc;
        int          bad;
        logic [31:0] ra;
        bit [7:0]    b;

        for (int i = 0; i < (1 << AW); i++) begin
            b = 8'($urandom);
            sim_ram[i] = b;
            ref_mem[i] = b;
        end
        sim_ram[17'h200] = 8'h10; ref_mem[17'h200] = 8'h10;
        sim_ram[17'h201] = 8'h11; ref_mem[17'h201] = 8'h11;
        sim_ram[17'h202] = 8'h12; ref_mem[17'h202] = 8'h12;
        sim_ram[17'h203] = 8'h7F; ref_mem[17'h203] = 8'h7F;

        #2;
        chk("rst_stall_ce1", {31'h0, stallreq_o}, 32'h1);
        chk("rst_wr", {31'h0, ram_wr_o}, 32'h0);
        chk("rst_addr", {15'h0, ram_addr_o}, 32'h0);
        chk("rst_dout", {24'h0, ram_dout_o}, 32'h0);
        chk("rst_data", mem_data_o, 32'h0);
        mem_ce_i = 1'b0;
        #1;
        chk("rst_stall_ce0", {31'h0, stallreq_o}, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        idle(2);

        do_req(1'b1, 32'h0000_0100, 4'hF, 32'hA1B2C3D4, dd, dc);
        chk("word_store_done", dc, 5);
        idle(1);
        do_req(1'b0, 32'h0000_0100, 4'hF, 32'h0, dd, dc);
        chk("word_load_data", dd, 32'hA1B2C3D4);
        chk("word_load_done", dc, 6);
        do_req(1'b1, 32'h0000_0202, 4'b0100, 32'h00EE0000, dd, dc);
        chk("byte_store_done", dc, 2);
        idle(1);
        chk("byte_store_200", {24'h0, sim_ram[17'h200]}, 32'h10);
        chk("byte_store_201", {24'h0, sim_ram[17'h201]}, 32'h11);
        chk("byte_store_202", {24'h0, sim_ram[17'h202]}, 32'hEE);
        chk("byte_store_203", {24'h0, sim_ram[17'h203]}, 32'h7F);
        do_req(1'b0, 32'h0000_0203, 4'b1000, 32'h0, dd, dc);
        chk("byte_load_data", dd, 32'h7F000000);
`ifdef DMEM_LANE_SKIP_EN
        chk("byte_load_done", dc, 3);
`else
        chk("byte_load_done", dc, 6);
`endif
        do_req(1'b1, 32'h0000_0300, 4'h0, 32'hDEADBEEF, dd, dc);
        chk("zero_store_done", dc, 1);
        do_req(1'b0, 32'h0000_0300, 4'h0, 32'h0, dd, dc);
        chk("zero_load_data", dd, 32'h0);
`ifdef DMEM_LANE_SKIP_EN
        chk("zero_load_done", dc, 1);
`else
        chk("zero_load_done", dc, 6);
`endif
        idle(1);

        for (int t = 0; t < 400; t++) begin
            ra = $urandom & 32'hFFFE_0003;
            ra = ra | ($urandom_range(0, 1) ? 32'h0001_FFC0 : 32'h0000_0400);
            ra = ra | (32'($urandom_range(0, 15)) << 2);
            do_req(1'($urandom), ra, 4'($urandom), $urandom, dd, dc);
            idle($urandom_range(0, 2));
        end

        push(1'b1, 1'b0, 8'h0, last_addr, 32'h0);
        push(1'b1, 1'b1, 8'h44, 17'h100, 32'h0);
        ref_mem[17'h100] = 8'h44;
        mem_ce_i   = 1'b1;
        mem_we_i   = 1'b1;
        mem_addr_i = 32'h0000_0100;
        mem_sel_i  = 4'hF;
        mem_data_i = 32'h11223344;
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_wr", {31'h0, ram_wr_o}, 32'h0);
        mem_ce_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        last_addr = '0;
        #1;
        chk("post_rst_stall", {31'h0, stallreq_o}, 32'h0);
        chk("post_rst_wr", {31'h0, ram_wr_o}, 32'h0);
        chk("post_rst_addr", {15'h0, ram_addr_o}, 32'h0);
        chk("post_rst_dout", {24'h0, ram_dout_o}, 32'h0);
        chk("post_rst_data", mem_data_o, 32'h0);
        @(posedge clk); #1;
        idle(2);
        chk("rst_mid_100", {24'h0, sim_ram[17'h100]}, 32'h44);
        chk("rst_mid_101", {24'h0, sim_ram[17'h101]}, {24'h0, ref_mem[17'h101]});

        bad = 0;
        for (int i = 0; i < (1 << AW); i++)
            if (sim_ram[i] != ref_mem[i]) bad++;
        chk("ram_image", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
